// File: rtl/m_fetch_queue.sv
// ----------------------------------------------------------------------------
// m_fetch_queue
//   Instruction fetch front end between the instruction memory (m_imem) and
//   the IF stage. This block does four things:
//     - owns the fetch PC;
//     - issues one memory read at a time over the re/oe handshake;
//     - buffers returned words, with their PCs, in a DEPTH-entry FIFO;
//     - flushes on a processor redirect (branch or jump).
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  fetch PC loaded on reset (bits [1:0] must be 0)
//
// Ports
//   w_clk          in   clock, all state changes on posedge
//   w_rst          in   synchronous active-high reset
//   w_redirect     in   discard queue, continue fetching at w_redirect_pc
//   w_redirect_pc  in   redirect target, bits [1:0] treated as 0
//   w_deq          in   consume head entry this cycle
//   w_valid        out  head entry valid (queue not empty)
//   w_inst         out  head instruction word
//   w_inst_pc      out  PC of head instruction
//   w_mem_addr     out  read address to m_imem (current fetch PC)
//   w_mem_re       out  read request, one-cycle pulse per request
//   w_mem_rdata    in   read data from m_imem
//   w_mem_oe       in   read data valid for the single outstanding request
// ----------------------------------------------------------------------------
module m_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_redirect,
    input  logic [31:0] w_redirect_pc,
    input  logic        w_deq,
    output logic        w_valid,
    output logic [31:0] w_inst,
    output logic [31:0] w_inst_pc,
    output logic [31:0] w_mem_addr,
    output logic        w_mem_re,
    input  logic [31:0] w_mem_rdata,
    input  logic        w_mem_oe
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE  = 1;
    localparam logic [AW-1:0]  PTR_ONE  = 1;

    // WAIT: request outstanding, response is wanted.
    // DROP: request outstanding, response must be thrown away (redirected).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e        st_q, st_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   reqpc_q, reqpc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push;
    logic          pop;

    logic [31:0]   fifo_inst [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        st_d     = st_q;
        fpc_d    = fpc_q;
        reqpc_d  = reqpc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        w_mem_re = 1'b0;
        push     = 1'b0;

        unique case (st_q)
            ST_IDLE: begin
                // Issuing only while a slot is free reserves room for the
                // response, so a push can never find the FIFO full.
                if (!w_rst && !w_redirect && (cnt_q < FULL_CNT)) begin
                    w_mem_re = 1'b1;
                    reqpc_d  = fpc_q;
                    st_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_mem_oe) begin
                    push = !w_redirect;
                    st_d = ST_IDLE;
                end else if (w_redirect) begin
                    st_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (w_mem_oe) begin
                    st_d = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase

        pop = w_deq && (cnt_q != '0) && !w_redirect;

        if (push) begin
            fpc_d    = fpc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        // Redirect overrides push and pop: the queue restarts empty.
        if (w_redirect) begin
            fpc_d    = w_redirect_pc & 32'hFFFF_FFFC;
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            st_q     <= ST_IDLE;
            fpc_q    <= RESET_PC;
            reqpc_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            st_q     <= st_d;
            fpc_q    <= fpc_d;
            reqpc_q  <= reqpc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: FIFO storage is not reset; an entry is only read once the count
    // says it was written, so its power-up contents never matter.
    always_ff @(posedge w_clk) begin
        if (push) begin
            fifo_inst[wr_ptr_q] <= w_mem_rdata;
            fifo_pc[wr_ptr_q]   <= reqpc_q;
        end
    end

    assign w_valid    = (cnt_q != '0);
    assign w_inst     = fifo_inst[rd_ptr_q];
    assign w_inst_pc  = fifo_pc[rd_ptr_q];
    assign w_mem_addr = fpc_q;

endmodule

// File: tb/tb_m_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_m_fetch_queue
//   Self-checking bench for m_fetch_queue.
//   Two instances share the processor-side inputs:
//     dut0  RESET_PC = 0
//     dut1  RESET_PC = 0xFFFFFFF8, covers PC wrap-around
//   Each instance has its own behavioural memory with programmable latency
//   and contents mem[i] = i.
//   dut0's oe can also be pulsed by hand to create late responses.
// ----------------------------------------------------------------------------
module tb_m_fetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq;

    logic        valid0, re0, oe0, m0_oe, man_oe;
    logic [31:0] inst0, ipc0, addr0, rdata0;
    logic        valid1, re1, m1_oe;
    logic [31:0] inst1, ipc1, addr1, rdata1;

    int          lat;
    logic        mem_en;

    int          n_vec;
    int          n_err;

    assign oe0 = m0_oe | man_oe;

    m_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut0 (
        .w_clk(clk), .w_rst(rst), .w_redirect(redirect), .w_redirect_pc(redirect_pc),
        .w_deq(deq), .w_valid(valid0), .w_inst(inst0), .w_inst_pc(ipc0),
        .w_mem_addr(addr0), .w_mem_re(re0), .w_mem_rdata(rdata0), .w_mem_oe(oe0)
    );

    m_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut1 (
        .w_clk(clk), .w_rst(rst), .w_redirect(redirect), .w_redirect_pc(redirect_pc),
        .w_deq(deq), .w_valid(valid1), .w_inst(inst1), .w_inst_pc(ipc1),
        .w_mem_addr(addr1), .w_mem_re(re1), .w_mem_rdata(rdata1), .w_mem_oe(m1_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model for dut0: answers each request after 'lat' cycles.
    logic        m0_pend;
    int          m0_cnt;
    logic [31:0] m0_addr;
    always @(posedge clk) begin
        m0_oe <= 1'b0;
        if (rst || !mem_en) begin
            m0_pend <= 1'b0;
        end else begin
            if (m0_pend) begin
                if (m0_cnt == 1) begin
                    m0_oe   <= 1'b1;
                    rdata0  <= m0_addr >> 2;
                    m0_pend <= 1'b0;
                end else begin
                    m0_cnt <= m0_cnt - 1;
                end
            end
            if (re0) begin
                if (lat == 1) begin
                    m0_oe  <= 1'b1;
                    rdata0 <= addr0 >> 2;
                end else begin
                    m0_pend <= 1'b1;
                    m0_cnt  <= lat - 1;
                    m0_addr <= addr0;
                end
            end
        end
    end

    // Memory model for dut1: fixed 1-cycle latency.
    always @(posedge clk) begin
        m1_oe <= 1'b0;
        if (!rst && re1) begin
            m1_oe  <= 1'b1;
            rdata1 <= addr1 >> 2;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles, check reset outputs, then release. Returns in cycle 0.
    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        deq = 1'b0;
        man_oe = 1'b0;
        cyc();
        cyc();
        check("rst_valid0", {31'b0, valid0}, 32'd0);
        check("rst_re0", {31'b0, re0}, 32'd0);
        check("rst_addr0", addr0, 32'h0000_0000);
        check("rst_valid1", {31'b0, valid1}, 32'd0);
        check("rst_addr1", addr1, 32'hFFFF_FFF8);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        deq;
        logic        re;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic        valid;
        logic [31:0] pc0;
        logic [31:0] inst0;
        logic [31:0] pc1;
        logic [31:0] inst1;
    } vec_t;

    vec_t vecs[12];

    initial begin
        static int   re_cnt = 0;
        static logic found = 1'b0;

        n_vec  = 0;
        n_err  = 0;
        lat    = 1;
        mem_en = 1'b1;
        man_oe = 1'b0;

        // Streaming with w_deq=1 and 1-cycle memory. A request goes out every
        // 2nd cycle and each word is visible 2 cycles after its request.
        vecs[0]  = '{1'b1, 1'b1, 32'h0,  32'hFFFF_FFF8, 1'b0, 32'h0,  32'h0, 32'h0,         32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,  32'h0, 32'h0,         32'h0};
        vecs[2]  = '{1'b1, 1'b1, 32'h4,  32'hFFFF_FFFC, 1'b1, 32'h0,  32'h0, 32'hFFFF_FFF8, 32'h3FFF_FFFE};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,  32'h0, 32'h0,         32'h0};
        vecs[4]  = '{1'b1, 1'b1, 32'h8,  32'h0,         1'b1, 32'h4,  32'h1, 32'hFFFF_FFFC, 32'h3FFF_FFFF};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,  32'h0, 32'h0,         32'h0};
        vecs[6]  = '{1'b1, 1'b1, 32'hC,  32'h4,         1'b1, 32'h8,  32'h2, 32'h0,         32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,  32'h0, 32'h0,         32'h0};
        vecs[8]  = '{1'b1, 1'b1, 32'h10, 32'h8,         1'b1, 32'hC,  32'h3, 32'h4,         32'h1};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,  32'h0, 32'h0,         32'h0};
        vecs[10] = '{1'b1, 1'b1, 32'h14, 32'hC,         1'b1, 32'h10, 32'h4, 32'h8,         32'h2};
        vecs[11] = '{1'b1, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,  32'h0, 32'h0,         32'h0};

        // ---- Streaming table (both instances, incl. PC wrap on dut1) ----
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i != 0) cyc();
            deq = vecs[i].deq;
            #1;
            check($sformatf("v%0d_re0", i), {31'b0, re0}, {31'b0, vecs[i].re});
            check($sformatf("v%0d_re1", i), {31'b0, re1}, {31'b0, vecs[i].re});
            check($sformatf("v%0d_valid0", i), {31'b0, valid0}, {31'b0, vecs[i].valid});
            check($sformatf("v%0d_valid1", i), {31'b0, valid1}, {31'b0, vecs[i].valid});
            if (vecs[i].re) begin
                check($sformatf("v%0d_addr0", i), addr0, vecs[i].addr0);
                check($sformatf("v%0d_addr1", i), addr1, vecs[i].addr1);
            end
            if (vecs[i].valid) begin
                check($sformatf("v%0d_pc0", i), ipc0, vecs[i].pc0);
                check($sformatf("v%0d_inst0", i), inst0, vecs[i].inst0);
                check($sformatf("v%0d_pc1", i), ipc1, vecs[i].pc1);
                check($sformatf("v%0d_inst1", i), inst1, vecs[i].inst1);
            end
        end

        // ---- Fill with w_deq=0: exactly DEPTH requests, then stall ----
        do_reset();
        for (int i = 0; i < 14; i++) begin
            if (i != 0) cyc();
            #1;
            if (re0) re_cnt++;
        end
        check("fill_req_count", re_cnt, 4);
        check("fill_re_idle", {31'b0, re0}, 32'd0);
        check("fill_head_pc", ipc0, 32'h0);
        cyc();
        deq = 1'b1;
        #1;
        check("fill_full_no_re", {31'b0, re0}, 32'd0);
        cyc();
        deq = 1'b0;
        #1;
        check("fill_refill_re", {31'b0, re0}, 32'd1);
        check("fill_refill_addr", addr0, 32'h10);
        check("fill_head_after_pop", ipc0, 32'h4);
        for (int i = 0; i < 3; i++) cyc();
        for (int k = 0; k < 4; k++) begin
            cyc();
            deq = 1'b1;
            #1;
            check($sformatf("fill_drain%0d_pc", k), ipc0, 32'(4 + 4 * k));
            check($sformatf("fill_drain%0d_inst", k), inst0, 32'(1 + k));
        end
        deq = 1'b0;

        // ---- 3-cycle memory, redirect to 0x100 while in WAIT ----
        lat = 3;
        do_reset();
        #1;
        check("wait_re", {31'b0, re0}, 32'd1);
        cyc();
        redirect = 1'b1;
        redirect_pc = 32'h100;
        #1;
        check("wait_redir_no_re", {31'b0, re0}, 32'd0);
        cyc();
        redirect = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (valid0) begin
                found = 1'b1;
                check("wait_first_pc", ipc0, 32'h100);
                check("wait_first_inst", inst0, 32'h40);
            end else begin
                cyc();
            end
        end
        if (!found) check("wait_timeout_valid", 32'd0, 32'd1);

        // ---- Redirect to 0x203 together with oe and deq ----
        lat = 1;
        do_reset();
        cyc();
        cyc();
        cyc();
        redirect = 1'b1;
        redirect_pc = 32'h203;
        deq = 1'b1;
        #1;
        check("same_pre_valid", {31'b0, valid0}, 32'd1);
        cyc();
        redirect = 1'b0;
        deq = 1'b0;
        #1;
        check("same_empty", {31'b0, valid0}, 32'd0);
        check("same_addr", addr0, 32'h200);
        check("same_re", {31'b0, re0}, 32'd1);
        cyc();
        cyc();
        #1;
        check("same_new_pc", ipc0, 32'h200);
        check("same_new_inst", inst0, 32'h80);

        // ---- Reset in DROP, then a late oe ----
        mem_en = 1'b0;
        lat = 3;
        do_reset();
        cyc();
        redirect = 1'b1;
        redirect_pc = 32'h40;
        cyc();
        redirect = 1'b0;
        #1;
        check("drop_no_re", {31'b0, re0}, 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        man_oe = 1'b1;
        #1;
        check("drop_rst_re", {31'b0, re0}, 32'd1);
        check("drop_rst_addr", addr0, 32'h0);
        check("drop_rst_valid", {31'b0, valid0}, 32'd0);
        cyc();
        man_oe = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("drop_late_valid%0d", i), {31'b0, valid0}, 32'd0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
